// File: rtl/turn_sequencer_if.sv
// Command handshake bundle between the driving FSM (master) and the turn
// sequencer (slave).
interface turn_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;

  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ready
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: command-driven turn controller. A taken command drives
// turn_left/turn_right for the command's on-time, waits out the settle
// interval, then pulses done. One command can be buffered while busy.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing active, waiting for a command
// TURN   | turn output high, cnt counts the on-time
// SETTLE | turn outputs low, cnt continues up to the total length
// DONE   | single cycle with done=1; launches pending/offered command
module turn_sequencer #(
  parameter int CNT_W      = 12,
  parameter int T90_ON     = 750,
  parameter int T90_TOTAL  = 1000,
  parameter int T180_ON    = 1700,
  parameter int T180_TOTAL = 2000
) (
  input  logic            clk_ms,
  input  logic            rst,
  turn_sequencer_if.slave cmd_if,
  input  logic            pause,
  input  logic            abort,
  output logic            turn_left,
  output logic            turn_right,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Phase limits are stored as "last count" so each phase ends on an
  // equality compare against the running up-counter.
  localparam logic [CNT_W-1:0] ON90_LAST     = CNT_W'(T90_ON - 1);
  localparam logic [CNT_W-1:0] TOTAL90_LAST  = CNT_W'(T90_TOTAL - 1);
  localparam logic [CNT_W-1:0] ON180_LAST    = CNT_W'(T180_ON - 1);
  localparam logic [CNT_W-1:0] TOTAL180_LAST = CNT_W'(T180_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur_cmd;
  logic [1:0]       pend_cmd;
  logic             pend_valid;
  logic             handshake;
  logic [CNT_W-1:0] on_last;
  logic [CNT_W-1:0] total_last;

  // Ready drops as soon as the buffer is full or an abort is asserted, so
  // an abort can never coincide with a taken command.
  assign cmd_if.cmd_ready = ~pend_valid & ~abort;
  assign handshake        = cmd_if.cmd_valid & cmd_if.cmd_ready;

  // Bit 1 of the command selects the 180 degree timing set.
  assign on_last    = cur_cmd[1] ? ON180_LAST    : ON90_LAST;
  assign total_last = cur_cmd[1] ? TOTAL180_LAST : TOTAL90_LAST;

  // Sequencing FSM with registered outputs; priority rst > abort > pause.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_cmd    <= 2'b00;
      pend_cmd   <= 2'b00;
      pend_valid <= 1'b0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else if (abort) begin
      // Kill everything; only a sequencer that was doing work reports it.
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= (state != IDLE);
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (handshake) begin
            state      <= TURN;
            cur_cmd    <= cmd_if.cmd;
            cnt        <= '0;
            turn_left  <= ~cmd_if.cmd[0];
            turn_right <= cmd_if.cmd[0];
            busy       <= 1'b1;
          end
        end

        TURN: begin
          if (handshake) begin
            pend_cmd   <= cmd_if.cmd;
            pend_valid <= 1'b1;
          end
          if (pause) begin
            // Count frozen; output dropped but remaining on-time kept.
            turn_left  <= 1'b0;
            turn_right <= 1'b0;
          end else if (cnt == on_last) begin
            state      <= SETTLE;
            cnt        <= cnt + CNT_ONE;
            turn_left  <= 1'b0;
            turn_right <= 1'b0;
          end else begin
            cnt        <= cnt + CNT_ONE;
            turn_left  <= ~cur_cmd[0];
            turn_right <= cur_cmd[0];
          end
        end

        SETTLE: begin
          if (handshake) begin
            pend_cmd   <= cmd_if.cmd;
            pend_valid <= 1'b1;
          end
          if (!pause) begin
            if (cnt == total_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        DONE: begin
          // Buffered command wins; ready is low while it is held, so a
          // fresh offer can only be taken when the buffer is empty.
          if (pend_valid) begin
            state      <= TURN;
            cur_cmd    <= pend_cmd;
            pend_valid <= 1'b0;
            cnt        <= '0;
            turn_left  <= ~pend_cmd[0];
            turn_right <= pend_cmd[0];
          end else if (handshake) begin
            state      <= TURN;
            cur_cmd    <= cmd_if.cmd;
            cnt        <= '0;
            turn_left  <= ~cmd_if.cmd[0];
            turn_right <= cmd_if.cmd[0];
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The motor mux must never see both directions requested at once.
  assert property (@(posedge clk_ms) !(turn_left && turn_right));

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer with short timing (90: 3/5, 180: 6/8).
// Directed cycle tables feed an expected-output queue; a random soak
// checks output invariants.
module tb_turn_sequencer;

  logic clk_ms = 1'b0;
  logic rst    = 1'b0;
  logic pause  = 1'b0;
  logic abort  = 1'b0;
  logic turn_left, turn_right, busy, done, aborted;

  turn_sequencer_if cmd_if ();

  turn_sequencer #(
    .CNT_W     (12),
    .T90_ON    (3),
    .T90_TOTAL (5),
    .T180_ON   (6),
    .T180_TOTAL(8)
  ) dut (
    .clk_ms    (clk_ms),
    .rst       (rst),
    .cmd_if    (cmd_if),
    .pause     (pause),
    .abort     (abort),
    .turn_left (turn_left),
    .turn_right(turn_right),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk_ms = ~clk_ms;

  // Output bundle order: {turn_left, turn_right, busy, done, aborted}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_TL   = 5'b10100;
  localparam logic [4:0] O_TR   = 5'b01100;
  localparam logic [4:0] O_BUSY = 5'b00100;
  localparam logic [4:0] O_DONE = 5'b00110;
  localparam logic [4:0] O_ABT  = 5'b00001;

  typedef struct packed {
    logic [15:0] id;
    logic        rst;
    logic        valid;
    logic [1:0]  cmd;
    logic        pause;
    logic        abort;
    logic        chk_rdy;
    logic        rdy;
    logic [4:0]  outs;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int         checks   = 0;
  int         failures = 0;

  // rdy < 0 means cmd_ready is not checked on that row.
  task automatic add(input int id, input bit r, input bit v, input logic [1:0] c,
                     input bit p, input bit a, input int rdy, input logic [4:0] o);
    vec_t t;
    t.id      = 16'(id);
    t.rst     = r;
    t.valid   = v;
    t.cmd     = c;
    t.pause   = p;
    t.abort   = a;
    t.chk_rdy = (rdy >= 0);
    t.rdy     = (rdy > 0);
    t.outs    = o;
    vecs.push_back(t);
  endtask

  initial begin
    logic [4:0] exp_o;
    logic [4:0] got_o;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd       = 2'b00;

    // Reset, then left 90
    add(101, 1, 0, 2'b00, 0, 0, -1, O_IDLE);
    add(102, 1, 0, 2'b00, 0, 0,  1, O_IDLE);
    add(103, 0, 1, 2'b00, 0, 0,  1, O_TL);
    add(104, 0, 0, 2'b00, 0, 0,  1, O_TL);
    add(105, 0, 0, 2'b00, 0, 0,  1, O_TL);
    add(106, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(107, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(108, 0, 0, 2'b00, 0, 0,  1, O_DONE);
    add(109, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    // Around-right with left 90 pending; offer at 205 is refused
    add(201, 0, 1, 2'b11, 0, 0,  1, O_TR);
    add(202, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(203, 0, 1, 2'b00, 0, 0,  1, O_TR);
    add(204, 0, 0, 2'b00, 0, 0,  0, O_TR);
    add(205, 0, 1, 2'b01, 0, 0,  0, O_TR);
    add(206, 0, 0, 2'b00, 0, 0,  0, O_TR);
    add(207, 0, 0, 2'b00, 0, 0,  0, O_BUSY);
    add(208, 0, 0, 2'b00, 0, 0,  0, O_BUSY);
    add(209, 0, 0, 2'b00, 0, 0,  0, O_DONE);
    add(210, 0, 0, 2'b00, 0, 0,  0, O_TL);
    add(211, 0, 0, 2'b00, 0, 0,  1, O_TL);
    add(212, 0, 0, 2'b00, 0, 0,  1, O_TL);
    add(213, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(214, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(215, 0, 0, 2'b00, 0, 0,  1, O_DONE);
    add(216, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    // Right 90: two paused cycles in TURN, one in SETTLE, pause in DONE
    add(301, 0, 1, 2'b01, 0, 0,  1, O_TR);
    add(302, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(303, 0, 0, 2'b00, 1, 0,  1, O_BUSY);
    add(304, 0, 0, 2'b00, 1, 0,  1, O_BUSY);
    add(305, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(306, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(307, 0, 0, 2'b00, 1, 0,  1, O_BUSY);
    add(308, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(309, 0, 0, 2'b00, 0, 0,  1, O_DONE);
    add(310, 0, 0, 2'b00, 1, 0,  1, O_IDLE);
    // Around-left aborted with a pending command; then abort in IDLE
    add(401, 0, 1, 2'b10, 0, 0,  1, O_TL);
    add(402, 0, 1, 2'b01, 0, 0,  1, O_TL);
    add(403, 0, 0, 2'b00, 0, 0,  0, O_TL);
    add(404, 0, 0, 2'b00, 0, 0,  0, O_TL);
    add(405, 0, 0, 2'b00, 0, 1,  0, O_ABT);
    add(406, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    add(407, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    add(408, 0, 1, 2'b00, 0, 1,  0, O_IDLE);
    add(409, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    // Offer in DONE with empty buffer; abort while in DONE
    add(501, 0, 1, 2'b00, 0, 0,  1, O_TL);
    add(502, 0, 0, 2'b00, 0, 0,  1, O_TL);
    add(503, 0, 0, 2'b00, 0, 0,  1, O_TL);
    add(504, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(505, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(506, 0, 0, 2'b00, 0, 0,  1, O_DONE);
    add(507, 0, 1, 2'b01, 0, 0,  1, O_TR);
    add(508, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(509, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(510, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(511, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(512, 0, 0, 2'b00, 0, 0,  1, O_DONE);
    add(513, 0, 0, 2'b00, 0, 1,  0, O_ABT);
    add(514, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    add(515, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    // Abort wins over pause during SETTLE
    add(601, 0, 1, 2'b11, 0, 0,  1, O_TR);
    add(602, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(603, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(604, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(605, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(606, 0, 0, 2'b00, 0, 0,  1, O_TR);
    add(607, 0, 0, 2'b00, 0, 0,  1, O_BUSY);
    add(608, 0, 0, 2'b00, 1, 1,  0, O_ABT);
    add(609, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    // Reset mid-TURN with a pending command: silent drop
    add(701, 0, 1, 2'b11, 0, 0,  1, O_TR);
    add(702, 0, 1, 2'b00, 0, 0,  1, O_TR);
    add(703, 1, 0, 2'b00, 0, 0,  0, O_IDLE);
    add(704, 0, 0, 2'b00, 0, 0,  1, O_IDLE);
    add(705, 0, 0, 2'b00, 0, 0,  1, O_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_ms);
      rst              = vecs[i].rst;
      cmd_if.cmd_valid = vecs[i].valid;
      cmd_if.cmd       = vecs[i].cmd;
      pause            = vecs[i].pause;
      abort            = vecs[i].abort;
      sb.push_back(vecs[i].outs);
      #1;
      if (vecs[i].chk_rdy) begin
        checks++;
        if (cmd_if.cmd_ready !== vecs[i].rdy) begin
          failures++;
          $display("FAIL cmd_ready row=%0d got=%b exp=%b", vecs[i].id, cmd_if.cmd_ready, vecs[i].rdy);
        end
      end
      @(posedge clk_ms);
      #1;
      exp_o = sb.pop_front();
      got_o = {turn_left, turn_right, busy, done, aborted};
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL outputs row=%0d got(tl,tr,busy,done,abt)=%b exp=%b", vecs[i].id, got_o, exp_o);
      end
    end

    // Random soak: direction exclusion and idle-quietness invariants
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_ms);
      rst              = ($urandom_range(0, 199) == 0);
      cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_if.cmd       = 2'($urandom_range(0, 3));
      pause            = ($urandom_range(0, 9) == 0);
      abort            = ($urandom_range(0, 59) == 0);
      @(posedge clk_ms);
      #1;
      checks++;
      if (turn_left && turn_right) begin
        failures++;
        $display("FAIL soak_exclusive cycle=%0d got tl=%b tr=%b exp not both 1", n, turn_left, turn_right);
      end
      checks++;
      if (!busy && (turn_left || turn_right || done)) begin
        failures++;
        $display("FAIL soak_idle_quiet cycle=%0d got busy=%b tl=%b tr=%b done=%b exp all low when not busy",
                 n, busy, turn_left, turn_right, done);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
